ifetch_queue: RTL

- Instruction prefetch buffer upstream of the IF stage.
- Issues sequential word fetches to a synchronous, in-order instruction memory port and buffers the returned {pc, instr} pairs in a small FIFO.
- Presents them to the pipeline front end with a valid/ready handshake; ready is driven by ~StallF.
- Handles branch/jump redirects from EX (PCSrcE/PCTargetE) by flushing buffered entries and discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/ifq_fifo.sv | 53 +++++
 rtl/ifetch_queue.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
package fetch_pkg;

   localparam int IFQ_XLEN    = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [IFQ_XLEN-1:0] pc;
      logic [31:0]         instr;
   } ifq_entry_t;

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap freely.
module ifq_fifo
   import fetch_pkg::*;
#(
   parameter type T     = logic [31:0],
   parameter int  DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  T                         wdata,
   input  logic                     pop,
   output T                         rdata,
   output logic                     empty,
   output logic                     full,
   output logic [ptr_width(DEPTH):0] count
);

   localparam int PW = ptr_width(DEPTH);

   T               mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == (PW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !flush) begin
         assert (!(push && full && !pop)) else $error("ifq_fifo overflow");
         assert (!(pop && empty)) else $error("ifq_fifo underflow");
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch buffer: sequential fetch issue, in-flight PC tagging, redirect flush.
// Optional same-cycle response bypass to the front end when IFQ_BYPASS_EN is defined.
module ifetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] fetch_pc,
   output logic [31:0]     fetch_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int CW = ptr_width(DEPTH) + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } entry_t;

   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] tag_head;
   logic [CW-1:0]   dcount;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;
   logic [CW:0]     occupancy;
   entry_t          dq_head;
   entry_t          rsp_entry;
   entry_t          head;
   entry_t          last_q;
   logic            dq_empty, dq_full, tq_empty, tq_full;
   logic            req_fire, drop, bypass, dq_push, dq_pop;

   // Buffered entries plus responses still owed must never exceed the queue.
   assign occupancy      = {1'b0, dcount} + {1'b0, outstanding};
   assign imem_req_valid = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
   assign imem_req_addr  = pc_next;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign drop      = (discard != '0);
   assign rsp_entry = '{pc: tag_head, instr: imem_rsp_data};

`ifdef IFQ_BYPASS_EN
   assign bypass = dq_empty && !drop && !redirect_valid && imem_rsp_valid;
`else
   assign bypass = 1'b0;
`endif

   assign fetch_valid = !reset && !redirect_valid && (!dq_empty || bypass);
   assign head        = !dq_empty ? dq_head : (bypass ? rsp_entry : last_q);
   assign fetch_pc    = head.pc;
   assign fetch_instr = head.instr;

   assign dq_pop  = fetch_valid && fetch_ready && !dq_empty;
   assign dq_push = imem_rsp_valid && !drop && !redirect_valid && !(bypass && fetch_ready);

   ifq_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_data_q (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (dq_push),
      .wdata (rsp_entry),
      .pop   (dq_pop),
      .rdata (dq_head),
      .empty (dq_empty),
      .full  (dq_full),
      .count (dcount)
   );

   // Tags survive redirects: stale responses still need their tag popped.
   ifq_fifo #(.T(logic [XLEN-1:0]), .DEPTH(DEPTH)) u_tag_q (
      .clk   (clk),
      .reset (reset),
      .flush (1'b0),
      .push  (req_fire),
      .wdata (pc_next),
      .pop   (imem_rsp_valid),
      .rdata (tag_head),
      .empty (tq_empty),
      .full  (tq_full),
      .count (outstanding)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_next <= RESET_PC;
         discard <= '0;
      end else if (redirect_valid) begin
         pc_next <= {redirect_pc[XLEN-1:2], 2'b00};
         discard <= outstanding - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) pc_next <= pc_next + XLEN'(INSTR_BYTES);
         if (imem_rsp_valid && drop) discard <= discard - CW'(1);
      end
   end

   // Holds the last presented entry so outputs stay stable while empty.
   always_ff @(posedge clk) begin
      if (reset)            last_q <= '0;
      else if (fetch_valid) last_q <= head;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(imem_rsp_valid && tq_empty)) else $error("response with no request outstanding");
         assert (!(req_fire && tq_full)) else $error("tag queue overflow");
         assert (!(dq_push && dq_full && !dq_pop)) else $error("data queue overflow");
      end
   end

endmodule
